// File: rtl/filter_bank_fsm_pkg.sv
// Shared widths and lane-state encoding for the multi-lane neighbour filter bank.
package filter_bank_fsm_pkg;

  localparam int unsigned PARTICLE_ID_WIDTH    = 7;
  localparam int unsigned POS_PKT_STRUCT_WIDTH = 24;
  localparam int unsigned NUM_FILTERS_DEFAULT  = 4;

  typedef logic [1:0] filter_state_t;

  localparam filter_state_t WAITING   = 2'd0;
  localparam filter_state_t FILTERING = 2'd1;
  localparam filter_state_t SPINNING  = 2'd2;

endpackage

// File: rtl/filter_bank_fsm_lane.sv
// One filter lane: holds a neighbour particle, counts evaluations against the home stream,
// and checkpoints/replays the home particle it missed while the downstream buffer was full.
module filter_bank_fsm_lane
  import filter_bank_fsm_pkg::*;
#(
  parameter int unsigned CntWidth = PARTICLE_ID_WIDTH + 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            load_i,
  input  logic [POS_PKT_STRUCT_WIDTH-1:0] pos_i,
  input  logic                            from_home_i,
  input  logic [PARTICLE_ID_WIDTH-1:0]    home_parid_i,
  input  logic                            home_advance_i,
  input  logic [CntWidth-1:0]             home_num_i,
  input  logic                            almost_full_i,
  output logic                            waiting_o,
  output logic [POS_PKT_STRUCT_WIDTH-1:0] nb_reg_o,
  output logic                            from_home_o,
  output logic                            filtering_o,
  output logic                            back_pressure_o,
  output logic                            done_o
);

  filter_state_t                   state_q, state_d;
  logic [CntWidth-1:0]             cnt_q, cnt_d;
  logic [PARTICLE_ID_WIDTH-1:0]    ckpt_q, ckpt_d;
  logic [POS_PKT_STRUCT_WIDTH-1:0] pos_q, pos_d;
  logic                            home_q, home_d;
  logic                            flag_q, flag_d;
  logic                            bp_q, bp_d;
  logic                            done_q, done_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ckpt_d  = ckpt_q;
    pos_d   = pos_q;
    home_d  = home_q;
    flag_d  = flag_q;
    bp_d    = bp_q;
    done_d  = 1'b0;
    unique case (state_q)
      WAITING: begin
        if (load_i) begin
          state_d = FILTERING;
          pos_d   = pos_i;
          home_d  = from_home_i;
          cnt_d   = '0;
          flag_d  = 1'b1;
        end
      end
      FILTERING: begin
        // An empty home cell has nothing to meet, so the lane retires without evaluating.
        if (home_num_i == '0) begin
          state_d = WAITING;
          flag_d  = 1'b0;
          done_d  = 1'b1;
        end else if (almost_full_i) begin
          state_d = SPINNING;
          ckpt_d  = home_parid_i;
          flag_d  = 1'b0;
          bp_d    = 1'b1;
        end else if (home_advance_i) begin
          cnt_d = cnt_q + CntWidth'(1);
          if (cnt_q == home_num_i - CntWidth'(1)) begin
            state_d = WAITING;
            flag_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      SPINNING: begin
        if ((home_parid_i == ckpt_q) && !almost_full_i) begin
          state_d = FILTERING;
          flag_d  = 1'b1;
          bp_d    = 1'b0;
        end
      end
      default: state_d = WAITING;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WAITING;
      cnt_q   <= '0;
      ckpt_q  <= '0;
      pos_q   <= '0;
      home_q  <= 1'b0;
      flag_q  <= 1'b0;
      bp_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ckpt_q  <= ckpt_d;
      pos_q   <= pos_d;
      home_q  <= home_d;
      flag_q  <= flag_d;
      bp_q    <= bp_d;
      done_q  <= done_d;
    end
  end

  assign waiting_o       = (state_q == WAITING);
  assign nb_reg_o        = pos_q;
  assign from_home_o     = home_q;
  assign filtering_o     = flag_q;
  assign back_pressure_o = bp_q;
  assign done_o          = done_q;

endmodule

// File: rtl/filter_bank_fsm.sv
// Bank of independent filter lanes; a new neighbour goes to the lowest-index idle lane.
module filter_bank_fsm
  import filter_bank_fsm_pkg::*;
#(
  parameter int unsigned NUM_FILTERS = NUM_FILTERS_DEFAULT,
  parameter int unsigned CNT_WIDTH   = PARTICLE_ID_WIDTH + 1
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic [PARTICLE_ID_WIDTH-1:0]                i_home_parid,
  input  logic                                        i_home_advance,
  input  logic [CNT_WIDTH-1:0]                        i_home_num,
  input  logic [POS_PKT_STRUCT_WIDTH-1:0]             i_nb_pos,
  input  logic                                        i_nb_from_home_cell_flag,
  input  logic                                        i_nb_valid,
  input  logic [NUM_FILTERS-1:0]                      i_almost_full,
  output logic                                        o_nb_ready,
  output logic [NUM_FILTERS*POS_PKT_STRUCT_WIDTH-1:0] o_nb_reg,
  output logic [NUM_FILTERS-1:0]                      o_nb_from_home_cell,
  output logic [NUM_FILTERS-1:0]                      o_filtering_flag,
  output logic [NUM_FILTERS-1:0]                      o_back_pressure,
  output logic [NUM_FILTERS-1:0]                      o_lane_done
);

  logic [NUM_FILTERS-1:0] waiting;
  logic [NUM_FILTERS-1:0] load;
  logic                   found;

  always_comb begin
    load  = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NUM_FILTERS; k++) begin
      if (!found && waiting[k]) begin
        load[k] = i_nb_valid;
        found   = 1'b1;
      end
    end
  end

  // Ready depends only on registered state, so a lane freed this cycle is offered next cycle.
  assign o_nb_ready = |waiting;

  for (genvar k = 0; k < NUM_FILTERS; k++) begin : g_lane
    filter_bank_fsm_lane #(
      .CntWidth(CNT_WIDTH)
    ) u_lane (
      .clk            (clk),
      .rst_n          (rst_n),
      .load_i         (load[k]),
      .pos_i          (i_nb_pos),
      .from_home_i    (i_nb_from_home_cell_flag),
      .home_parid_i   (i_home_parid),
      .home_advance_i (i_home_advance),
      .home_num_i     (i_home_num),
      .almost_full_i  (i_almost_full[k]),
      .waiting_o      (waiting[k]),
      .nb_reg_o       (o_nb_reg[k*POS_PKT_STRUCT_WIDTH +: POS_PKT_STRUCT_WIDTH]),
      .from_home_o    (o_nb_from_home_cell[k]),
      .filtering_o    (o_filtering_flag[k]),
      .back_pressure_o(o_back_pressure[k]),
      .done_o         (o_lane_done[k])
    );
  end

endmodule

// File: tb/tb_filter_bank_fsm.sv
// Directed bench for the filter bank: reset, counting, empty/single home cells, replay, fill.
module tb_filter_bank_fsm;
  import filter_bank_fsm_pkg::*;

  localparam int unsigned NF = 4;
  localparam int unsigned CW = PARTICLE_ID_WIDTH + 1;
  localparam int unsigned PW = POS_PKT_STRUCT_WIDTH;

  logic                         clk = 1'b0;
  logic                         rst_n;
  logic [PARTICLE_ID_WIDTH-1:0] i_home_parid;
  logic                         i_home_advance;
  logic [CW-1:0]                i_home_num;
  logic [PW-1:0]                i_nb_pos;
  logic                         i_nb_from_home_cell_flag;
  logic                         i_nb_valid;
  logic [NF-1:0]                i_almost_full;
  logic                         o_nb_ready;
  logic [NF*PW-1:0]             o_nb_reg;
  logic [NF-1:0]                o_nb_from_home_cell;
  logic [NF-1:0]                o_filtering_flag;
  logic [NF-1:0]                o_back_pressure;
  logic [NF-1:0]                o_lane_done;

  int checks = 0;
  int errors = 0;

  filter_bank_fsm #(
    .NUM_FILTERS(NF),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .i_home_parid            (i_home_parid),
    .i_home_advance          (i_home_advance),
    .i_home_num              (i_home_num),
    .i_nb_pos                (i_nb_pos),
    .i_nb_from_home_cell_flag(i_nb_from_home_cell_flag),
    .i_nb_valid              (i_nb_valid),
    .i_almost_full           (i_almost_full),
    .o_nb_ready              (o_nb_ready),
    .o_nb_reg                (o_nb_reg),
    .o_nb_from_home_cell     (o_nb_from_home_cell),
    .o_filtering_flag        (o_filtering_flag),
    .o_back_pressure         (o_back_pressure),
    .o_lane_done             (o_lane_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n                    = 1'b0;
    i_home_parid             = '0;
    i_home_advance           = 1'b0;
    i_home_num               = '0;
    i_nb_pos                 = '0;
    i_nb_from_home_cell_flag = 1'b0;
    i_nb_valid               = 1'b0;
    i_almost_full            = '0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (o_nb_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %b exp 1", o_nb_ready);
    end
    checks++;
    if ({o_nb_reg, o_nb_from_home_cell, o_filtering_flag, o_back_pressure, o_lane_done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %h exp 0",
               {o_nb_reg, o_nb_from_home_cell, o_filtering_flag, o_back_pressure, o_lane_done});
    end
  endtask

  task automatic test_basic();
    int flag_cyc = 0;
    int done_cnt = 0;
    int done_at  = -1;
    apply_reset();
    i_home_num               = CW'(4);
    i_home_advance           = 1'b1;
    i_nb_pos                 = 24'h00A1B2;
    i_nb_from_home_cell_flag = 1'b1;
    i_nb_valid               = 1'b1;
    tick();
    i_nb_valid               = 1'b0;
    i_nb_from_home_cell_flag = 1'b0;
    checks++;
    if (o_nb_reg[PW-1:0] !== 24'h00A1B2 || o_nb_from_home_cell[0] !== 1'b1) begin
      errors++;
      $display("FAIL basic_load got %h/%b exp 00a1b2/1", o_nb_reg[PW-1:0], o_nb_from_home_cell[0]);
    end
    for (int i = 0; i < 12; i++) begin
      if (o_filtering_flag[0]) flag_cyc++;
      if (o_lane_done[0]) begin
        done_cnt++;
        done_at = i;
      end
      i_home_parid = (i_home_parid == 3) ? '0 : i_home_parid + 1'b1;
      tick();
    end
    checks++;
    if (flag_cyc != 4) begin
      errors++;
      $display("FAIL basic_flag_cycles got %0d exp 4", flag_cyc);
    end
    checks++;
    if (done_cnt != 1 || done_at != 4) begin
      errors++;
      $display("FAIL basic_done got count %0d at %0d exp 1 at 4", done_cnt, done_at);
    end
    checks++;
    if (o_filtering_flag !== '0 || o_nb_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_idle got flag %b ready %b exp 0000 1", o_filtering_flag, o_nb_ready);
    end
  endtask

  task automatic test_empty();
    apply_reset();
    i_home_num     = '0;
    i_home_advance = 1'b1;
    i_nb_pos       = 24'h0000E0;
    i_nb_valid     = 1'b1;
    tick();
    i_nb_valid = 1'b0;
    checks++;
    if (o_filtering_flag !== 4'b0001 || o_lane_done !== 4'b0000) begin
      errors++;
      $display("FAIL empty_load got flag %b done %b exp 0001 0000", o_filtering_flag, o_lane_done);
    end
    tick();
    checks++;
    if (o_filtering_flag !== 4'b0000 || o_lane_done !== 4'b0001) begin
      errors++;
      $display("FAIL empty_done got flag %b done %b exp 0000 0001", o_filtering_flag, o_lane_done);
    end
    tick();
    checks++;
    if (o_lane_done !== 4'b0000) begin
      errors++;
      $display("FAIL empty_pulse got %b exp 0000", o_lane_done);
    end
  endtask

  task automatic test_single();
    apply_reset();
    i_home_num     = CW'(1);
    i_home_parid   = PARTICLE_ID_WIDTH'(7);
    i_home_advance = 1'b1;
    i_nb_pos       = 24'h000051;
    i_nb_valid     = 1'b1;
    tick();
    i_nb_valid = 1'b0;
    checks++;
    if (o_filtering_flag[0] !== 1'b1) begin
      errors++;
      $display("FAIL single_load got %b exp 1", o_filtering_flag[0]);
    end
    tick();
    checks++;
    if (o_lane_done[0] !== 1'b1 || o_filtering_flag[0] !== 1'b0) begin
      errors++;
      $display("FAIL single_done got done %b flag %b exp 1 0", o_lane_done[0], o_filtering_flag[0]);
    end
    tick();
    checks++;
    if (o_filtering_flag[0] !== 1'b0 || o_lane_done[0] !== 1'b0) begin
      errors++;
      $display("FAIL single_after got flag %b done %b exp 0 0", o_filtering_flag[0], o_lane_done[0]);
    end
  endtask

  task automatic test_backpressure();
    logic [PARTICLE_ID_WIDTH-1:0] pids [13] = '{0, 1, 2, 3, 4, 5, 0, 1, 2, 2, 3, 4, 5};
    logic                         afs  [13] = '{0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    int evals    = 0;
    int p2       = 0;
    int done_cnt = 0;
    int done_at  = -1;
    logic bp_seen = 1'b0;
    apply_reset();
    i_home_num     = CW'(6);
    i_home_advance = 1'b1;
    i_nb_pos       = 24'h0000BB;
    i_nb_valid     = 1'b1;
    tick();
    i_nb_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (o_lane_done[0]) begin
        done_cnt++;
        done_at = i;
      end
      i_home_parid     = (i < 13) ? pids[i] : '0;
      i_almost_full[0] = (i < 13) ? afs[i] : 1'b0;
      if (i == 3) bp_seen = o_back_pressure[0] & ~o_filtering_flag[0];
      if (o_filtering_flag[0] && !i_almost_full[0]) begin
        evals++;
        if (i_home_parid == 2) p2++;
      end
      tick();
    end
    checks++;
    if (bp_seen !== 1'b1) begin
      errors++;
      $display("FAIL bp_spinning got %b exp 1", bp_seen);
    end
    checks++;
    if (evals != 6 || p2 != 1) begin
      errors++;
      $display("FAIL bp_evals got %0d (parid2 %0d) exp 6 (1)", evals, p2);
    end
    checks++;
    if (done_cnt != 1 || done_at != 13) begin
      errors++;
      $display("FAIL bp_done got count %0d at %0d exp 1 at 13", done_cnt, done_at);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    i_home_num     = CW'(2);
    i_home_advance = 1'b0;
    i_nb_valid     = 1'b1;
    for (int i = 0; i < 4; i++) begin
      i_nb_pos = 24'hB00000 + PW'(i);
      tick();
    end
    i_nb_pos = 24'hB00004;
    tick();
    checks++;
    if (o_nb_ready !== 1'b0 || o_filtering_flag !== 4'b1111) begin
      errors++;
      $display("FAIL b2b_full got ready %b flag %b exp 0 1111", o_nb_ready, o_filtering_flag);
    end
    checks++;
    if (o_nb_reg !== {24'hB00003, 24'hB00002, 24'hB00001, 24'hB00000}) begin
      errors++;
      $display("FAIL b2b_regs got %h exp b00003b00002b00001b00000", o_nb_reg);
    end
    i_almost_full  = 4'b1101;
    i_home_advance = 1'b1;
    i_home_parid   = '0;
    tick();
    checks++;
    if (o_back_pressure !== 4'b1101 || o_filtering_flag !== 4'b0010) begin
      errors++;
      $display("FAIL b2b_spin got bp %b flag %b exp 1101 0010", o_back_pressure, o_filtering_flag);
    end
    i_home_parid = PARTICLE_ID_WIDTH'(1);
    tick();
    checks++;
    if (o_lane_done !== 4'b0010 || o_nb_ready !== 1'b1 || o_filtering_flag !== 4'b0000) begin
      errors++;
      $display("FAIL b2b_done got done %b ready %b flag %b exp 0010 1 0000",
               o_lane_done, o_nb_ready, o_filtering_flag);
    end
    i_home_advance = 1'b0;
    tick();
    i_nb_valid = 1'b0;
    checks++;
    if (o_filtering_flag !== 4'b0010 || o_nb_reg[2*PW-1:PW] !== 24'hB00004 || o_nb_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_refill got flag %b reg1 %h ready %b exp 0010 b00004 0",
               o_filtering_flag, o_nb_reg[2*PW-1:PW], o_nb_ready);
    end
  endtask

  // Continues from the back-to-back state: lane 1 filtering, lanes 0/2/3 spinning.
  task automatic test_reset_mid();
    logic done_seen = 1'b0;
    i_home_advance = 1'b1;
    i_almost_full  = '0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({o_nb_reg, o_nb_from_home_cell, o_filtering_flag, o_back_pressure, o_lane_done} !== '0
        || o_nb_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_clear got %h ready %b exp 0 1",
               {o_nb_reg, o_nb_from_home_cell, o_filtering_flag, o_back_pressure, o_lane_done},
               o_nb_ready);
    end
    for (int i = 0; i < 3; i++) begin
      if (i == 1) rst_n = 1'b1;
      tick();
      done_seen = done_seen | (|o_lane_done) | (|o_filtering_flag);
    end
    checks++;
    if (done_seen !== 1'b0) begin
      errors++;
      $display("FAIL midreset_nodone got activity %b exp 0", done_seen);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_empty();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/filter_bank_fsm.md
# filter_bank_FSM

Multi-lane successor to the single-neighbour filter controller in the force pipeline. It holds up to NUM_FILTERS neighbour particles at once. Each held particle is evaluated against the rotating home-cell particle stream until it has met every home particle exactly once. Completion is counted with an evaluation counter rather than detected by parid re-match, so it stays correct for a home cell of 0 or 1 particles. Each lane has its own backpressure, checkpoint and replay. The block sits between the neighbour-cell read port and the filter/force-evaluation array.

## Interface
Parameters:
- NUM_FILTERS, 4, number of independent lanes (≥1).
- CNT_WIDTH, PARTICLE_ID_WIDTH+1, width of the home-particle count and the per-lane evaluation counter.

Ports (clock and reset: one clock; reset is asynchronous and active-low):
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- i_home_parid  in  PARTICLE_ID_WIDTH  home particle currently presented to all lanes.
- i_home_advance  in  1  i_home_parid is a real evaluation slot this cycle.
- i_home_num  in  CNT_WIDTH  home-cell particle count; stable while any lane is busy.
- i_nb_pos  in  POS_PKT_STRUCT_WIDTH  incoming neighbour packet.
- i_nb_from_home_cell_flag  in  1  neighbour originates from the home cell.
- i_nb_valid  in  1  neighbour offered; upstream holds it until accepted.
- i_almost_full  in  NUM_FILTERS  per-lane downstream buffer almost full.
- o_nb_ready  out  1  at least one lane is WAITING (combinational from state).
- o_nb_reg  out  NUM_FILTERS*POS_PKT_STRUCT_WIDTH  per-lane held packet; lane k occupies slice k.
- o_nb_from_home_cell  out  NUM_FILTERS  per-lane flag.
- o_filtering_flag  out  NUM_FILTERS  lane is evaluating this cycle.
- o_back_pressure  out  NUM_FILTERS  lane is SPINNING.
- o_lane_done  out  NUM_FILTERS  1-cycle pulse when a lane finishes.

## Operation
- Lane states: WAITING, FILTERING, SPINNING.
- Accept: when i_nb_valid & o_nb_ready, the lowest-index WAITING lane loads pos and flag, clears its counter, sets the flag, and enters FILTERING. Exactly one lane loads per cycle.
- A lane's evaluation counts at cycle t when all hold: lane is FILTERING, i_home_advance=1, and i_almost_full[k]=0. The counter then increments.
- Done: a counted evaluation with cnt==i_home_num-1 moves the lane to WAITING, clears the flag and pulses o_lane_done.
- Empty home cell: if i_home_num==0, the first FILTERING cycle completes immediately (done pulse, no evaluation).
- Backpressure: in FILTERING with i_almost_full[k]=1, the lane captures ckpt=i_home_parid, clears the flag, sets back_pressure and enters SPINNING. That slot is not counted.
- Resume: in SPINNING with i_home_parid==ckpt and i_almost_full[k]=0, the lane returns to FILTERING, sets the flag and clears back_pressure. The counter is preserved, so the skipped particle is replayed.
- Precedence: done/backpressure decisions use the same cycle's inputs. If almost_full is high, the slot is never counted, so done cannot fire.
- A lane freed at t is not allocatable until t+1, because o_nb_ready reflects current state.
- Reset values: all outputs 0, except o_nb_ready, which is 1 after reset (every lane WAITING). All lanes WAITING, counters and ckpt 0. Reset mid-operation discards held particles with no done pulse.

## Timing
- Load: i_nb_valid&ready at t → o_filtering_flag[k]=1 and o_nb_reg valid at t+1.
- State, flag, back_pressure and done all update at the clock edge after the qualifying input cycle (1-cycle latency).
- Minimum occupancy for i_home_num=N with no stalls: N advancing cycles plus 1.

## Structure
- MD_pkg additions: filter_state_t enum {WAITING, FILTERING, SPINNING}; constant NUM_FILTERS_DEFAULT=4.
- One sub-module, filter_lane_FSM: a single lane (state, counter, ckpt, registers), instantiated NUM_FILTERS times via generate.
- The top level holds the lowest-index-free priority encoder and o_nb_ready.

## Test plan
- i_home_num=4, parids cycle 0..3 every cycle, one neighbour, no backpressure → flag high exactly 4 counted cycles, done pulse, lane 0 WAITING.
- i_home_num=0 → lane loads, done pulse on the next cycle, no counted evaluations.
- i_home_num=1, parid stuck at 7 → exactly 1 evaluation, then done (no hang).
- i_home_num=6: assert almost_full[0] at parid 2 for 3 cycles → SPINNING, ckpt=2. Resume when parid returns to 2; total counted = 6, parid 2 counted once.
- NUM_FILTERS=4: five back-to-back valids → lanes 0..3 fill, o_nb_ready=0, 5th held. Lane 1 done at t → 5th accepted into lane 1 at t+1.
- Assert rst_n low while two lanes are FILTERING/SPINNING → all outputs clear asynchronously, no done pulse, o_nb_ready=1.
